// File: rtl/div_32_seq.sv
// div_32_seq: sequential 32-bit radix-2 restoring divider.
// Quotient on LO, remainder on HI, start/done handshake, one quotient bit per clock.
// Optional feature macro: DIV_32_SIGNED_EN (defined = signed two's complement
// operands; undefined = unsigned-only divider with identical latency).
module div_32_seq (
   input  logic        clk,
   input  logic        clr,
   input  logic        start,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        done,
   output logic        div_by_zero,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int unsigned W  = 32;
   localparam int unsigned CW = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t          state;
   logic [W-1:0]    dvd;       // dividend shifter; quotient bits enter at the LSB
   logic [W-1:0]    dvs;       // divisor magnitude
   logic [W-1:0]    rem;       // partial remainder
   logic [CW-1:0]   cnt;
   logic            sign_q;
   logic            sign_r;
   logic            dbz;

   logic            a_neg_c;
   logic            b_neg_c;
   logic [W-1:0]    a_mag_c;
   logic [W-1:0]    b_mag_c;
   logic [W-1:0]    rem_sh_c;
   logic [W+1:0]    trial_c;
   logic [W-1:0]    q_fix_c;
   logic [W-1:0]    r_fix_c;

   // Operand magnitudes and signs seen on the start edge
`ifdef DIV_32_SIGNED_EN
   always_comb begin
      a_neg_c = A[W-1];
      b_neg_c = B[W-1];
      a_mag_c = a_neg_c ? W'(-A) : A;
      b_mag_c = b_neg_c ? W'(-B) : B;
   end
`else
   always_comb begin
      a_neg_c = 1'b0;
      b_neg_c = 1'b0;
      a_mag_c = A;
      b_mag_c = B;
   end
`endif

   // One restoring step; trial is kept two bits wider so a full-range unsigned
   // divisor cannot alias the sign of the difference
   always_comb begin
      rem_sh_c = {rem[W-2:0], dvd[W-1]};
      trial_c  = {1'b0, rem, dvd[W-1]} - {2'b00, dvs};
   end

   // Sign correction of the final quotient and remainder
   always_comb begin
      q_fix_c = sign_q ? W'(-dvd) : dvd;
      r_fix_c = sign_r ? W'(-rem) : rem;
   end

   // Control FSM, datapath registers and registered outputs
   always_ff @(posedge clk) begin
      if (clr) begin
         state       <= IDLE;
         dvd         <= '0;
         dvs         <= '0;
         rem         <= '0;
         cnt         <= '0;
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
         dbz         <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         HI          <= '0;
         LO          <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy   <= 1'b1;
                  sign_q <= a_neg_c ^ b_neg_c;
                  sign_r <= a_neg_c;
                  rem    <= '0;
                  cnt    <= '0;
                  if (B == '0) begin
                     dbz   <= 1'b1;
                     dvd   <= A;
                     state <= FIX;
                  end else begin
                     dbz   <= 1'b0;
                     dvd   <= a_mag_c;
                     dvs   <= b_mag_c;
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               if (trial_c[W+1]) begin
                  rem <= rem_sh_c;
               end else begin
                  rem <= trial_c[W-1:0];
               end
               dvd <= {dvd[W-2:0], ~trial_c[W+1]};
               cnt <= cnt + CW'(1);
               if (cnt == CW'(W-1)) begin
                  state <= FIX;
               end
            end
            FIX: begin
               if (dbz) begin
                  LO          <= '1;
                  HI          <= dvd;
                  div_by_zero <= 1'b1;
               end else begin
                  LO          <= q_fix_c;
                  HI          <= r_fix_c;
                  div_by_zero <= 1'b0;
               end
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_32_seq.sv
// tb_div_32_seq: self-checking bench for div_32_seq against a plain-arithmetic model.
module tb_div_32_seq;

   logic        clk = 1'b0;
   logic        clr;
   logic        start;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] HI;
   logic [31:0] LO;

   int checks   = 0;
   int failures = 0;

   div_32_seq dut (
      .clk         (clk),
      .clr         (clr),
      .start       (start),
      .A           (A),
      .B           (B),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .HI          (HI),
      .LO          (LO)
   );

   always #5 clk = ~clk;

   // Reference: language-level division on wide integers
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] lo, output logic [31:0] hi,
                                 output logic dz);
      longint na, nb, q, r;
      if (b == 32'd0) begin
         lo = 32'hFFFF_FFFF;
         hi = a;
         dz = 1'b1;
      end else begin
`ifdef DIV_32_SIGNED_EN
         na = longint'($signed(a));
         nb = longint'($signed(b));
`else
         na = longint'({32'd0, a});
         nb = longint'({32'd0, b});
`endif
         q  = na / nb;
         r  = na % nb;
         lo = 32'(q);
         hi = 32'(r);
         dz = 1'b0;
      end
   endfunction

   // Issue one division from the current time and wait (bounded) for done
   task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] lo, output logic [31:0] hi,
                          output logic dz, output logic busy_run, output logic busy_done);
      start = 1'b1;
      A     = a;
      B     = b;
      @(posedge clk);
      #1;
      start    = 1'b0;
      A        = $urandom;
      B        = $urandom;
      busy_run = busy;
      lat      = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = n;
            break;
         end
      end
      lo        = LO;
      hi        = HI;
      dz        = div_by_zero;
      busy_done = busy;
   endtask

   task automatic test_reset();
      clr   = 1'b1;
      start = 1'b1;
      A     = 32'd100;
      B     = 32'd7;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, div_by_zero} !== 3'b000) begin
         failures++;
         $display("FAIL reset_flags: busy/done/dbz=%b required 000", {busy, done, div_by_zero});
      end
      checks++;
      if (HI !== 32'd0 || LO !== 32'd0) begin
         failures++;
         $display("FAIL reset_hilo: HI=%h LO=%h required 0/0", HI, LO);
      end
      clr   = 1'b0;
      start = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle: busy=%b required 0", busy);
      end
   endtask

   task automatic test_directed();
      logic [31:0] av[4];
      logic [31:0] bv[4];
      logic [31:0] lo, hi, elo, ehi;
      logic        dz, edz, br, bd;
      int          lat;
      av = '{32'd100, -32'sd100, 32'd100, -32'sd100};
      bv = '{32'd7, 32'd7, -32'sd7, -32'sd7};
      for (int i = 0; i < 4; i++) begin
         run_div(av[i], bv[i], lat, lo, hi, dz, br, bd);
         model(av[i], bv[i], elo, ehi, edz);
         checks++;
         if (lat !== 33 || br !== 1'b1 || bd !== 1'b0) begin
            failures++;
            $display("FAIL dir_timing[%0d]: lat=%0d busy_run=%b busy_done=%b required 33/1/0", i, lat, br, bd);
         end
         checks++;
         if (lo !== elo || hi !== ehi || dz !== edz) begin
            failures++;
            $display("FAIL dir_result[%0d]: LO=%h HI=%h dbz=%b required %h %h %b", i, lo, hi, dz, elo, ehi, edz);
         end
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || LO !== elo || HI !== ehi) begin
         failures++;
         $display("FAIL done_pulse: done=%b LO=%h HI=%h required 0 %h %h", done, LO, HI, elo, ehi);
      end
`ifdef DIV_32_SIGNED_EN
      run_div(-32'sd100, 32'd7, lat, lo, hi, dz, br, bd);
      checks++;
      if (lo !== 32'hFFFF_FFF2 || hi !== 32'hFFFF_FFFE) begin
         failures++;
         $display("FAIL neg100_div7: LO=%h HI=%h required fffffff2 fffffffe", lo, hi);
      end
      run_div(32'h8000_0000, 32'hFFFF_FFFF, lat, lo, hi, dz, br, bd);
      checks++;
      if (lo !== 32'h8000_0000 || hi !== 32'd0 || dz !== 1'b0) begin
         failures++;
         $display("FAIL overflow: LO=%h HI=%h dbz=%b required 80000000 0 0", lo, hi, dz);
      end
`else
      run_div(32'hFFFF_FFFF, 32'd2, lat, lo, hi, dz, br, bd);
      checks++;
      if (lo !== 32'h7FFF_FFFF || hi !== 32'd1 || lat !== 33) begin
         failures++;
         $display("FAIL unsigned_max: LO=%h HI=%h lat=%0d required 7fffffff 1 33", lo, hi, lat);
      end
      run_div(32'h8000_0000, 32'hFFFF_FFFF, lat, lo, hi, dz, br, bd);
      checks++;
      if (lo !== 32'd0 || hi !== 32'h8000_0000 || dz !== 1'b0) begin
         failures++;
         $display("FAIL big_divisor: LO=%h HI=%h dbz=%b required 0 80000000 0", lo, hi, dz);
      end
`endif
      run_div(32'd100, 32'd7, lat, lo, hi, dz, br, bd);
      checks++;
      if (lo !== 32'd14 || hi !== 32'd2) begin
         failures++;
         $display("FAIL d100_div7: LO=%h HI=%h required e 2", lo, hi);
      end
   endtask

   task automatic test_div_by_zero();
      logic [31:0] lo, hi;
      logic        dz, br, bd;
      int          lat;
      run_div(32'd5, 32'd0, lat, lo, hi, dz, br, bd);
      checks++;
      if (lat !== 1 || bd !== 1'b0) begin
         failures++;
         $display("FAIL dbz_timing: lat=%0d busy_done=%b required 1/0", lat, bd);
      end
      checks++;
      if (lo !== 32'hFFFF_FFFF || hi !== 32'd5 || dz !== 1'b1) begin
         failures++;
         $display("FAIL dbz_result: LO=%h HI=%h dbz=%b required ffffffff 5 1", lo, hi, dz);
      end
      @(posedge clk);
      #1;
      checks++;
      if (div_by_zero !== 1'b1 || done !== 1'b0) begin
         failures++;
         $display("FAIL dbz_hold: dbz=%b done=%b required 1 0", div_by_zero, done);
      end
      run_div(32'd9, 32'd3, lat, lo, hi, dz, br, bd);
      checks++;
      if (lo !== 32'd3 || hi !== 32'd0 || dz !== 1'b0 || lat !== 33) begin
         failures++;
         $display("FAIL after_dbz: LO=%h HI=%h dbz=%b lat=%0d required 3 0 0 33", lo, hi, dz, lat);
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b, lo, hi, elo, ehi;
      logic        dz, edz, br, bd;
      int          lat;
      for (int i = 0; i < 24; i++) begin
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         if (i % 8 == 7) b = 32'd0;
         run_div(a, b, lat, lo, hi, dz, br, bd);
         model(a, b, elo, ehi, edz);
         checks++;
         if (lo !== elo || hi !== ehi || dz !== edz || lat !== (edz ? 1 : 33)) begin
            failures++;
            $display("FAIL random[%0d] %h/%h: LO=%h HI=%h dbz=%b lat=%0d required %h %h %b %0d",
                     i, a, b, lo, hi, dz, lat, elo, ehi, edz, edz ? 1 : 33);
         end
      end
   endtask

   task automatic test_interference();
      logic [31:0] a, b, elo, ehi, slo, shi;
      logic        edz;
      int          lat;
      bit          seen;
      a = $urandom;
      b = ($urandom >> 4) | 32'd1;
      model(a, b, elo, ehi, edz);
      start = 1'b1;
      A     = a;
      B     = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat   = -1;
      for (int n = 1; n <= 40; n++) begin
         if (n == 5) begin
            start = 1'b1;
            A     = 32'd1000;
            B     = 32'd3;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         A     = $urandom;
         if (done) begin
            lat = n;
            break;
         end
      end
      checks++;
      if (lat !== 33 || LO !== elo || HI !== ehi) begin
         failures++;
         $display("FAIL ignore_start: lat=%0d LO=%h HI=%h required 33 %h %h", lat, LO, HI, elo, ehi);
      end
      // abort with clr at edge 10
      slo   = LO;
      shi   = HI;
      start = 1'b1;
      A     = 32'd77;
      B     = 32'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1 || LO !== slo || HI !== shi) begin
         failures++;
         $display("FAIL mid_run: busy=%b LO=%h HI=%h required 1 %h %h", busy, LO, HI, slo, shi);
      end
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
         failures++;
         $display("FAIL clr_abort: busy=%b done=%b HI=%h LO=%h required 0 0 0 0", busy, done, HI, LO);
      end
      seen = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk);
         #1;
         if (done || busy) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++;
         $display("FAIL clr_no_done: activity=%b required 0", seen);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] lo, hi, elo, ehi, a, b;
      logic        dz, edz, br, bd;
      int          lat;
      run_div(32'd1234, 32'd10, lat, lo, hi, dz, br, bd);
      a = $urandom;
      b = ($urandom >> 8) | 32'd1;
      model(a, b, elo, ehi, edz);
      run_div(a, b, lat, lo, hi, dz, br, bd);
      checks++;
      if (lat !== 33 || lo !== elo || hi !== ehi || br !== 1'b1) begin
         failures++;
         $display("FAIL back_to_back: lat=%0d LO=%h HI=%h busy_run=%b required 33 %h %h 1",
                  lat, lo, hi, br, elo, ehi);
      end
   endtask

   initial begin
      clr   = 1'b0;
      start = 1'b0;
      A     = '0;
      B     = '0;
      test_reset();
      test_directed();
      test_div_by_zero();
      test_random();
      test_interference();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
